srff_bank_ctrl: RTL and testbench
=================================

# srff_bank_ctrl

Round-robin controller that shares a bank of NBITS clocked SR flip-flops between NREQ requesters. Each granted request becomes a single one-cycle, one-hot set or reset pulse on the bank's S/R inputs, so the forbidden S=R=1 input never occurs. The block also runs a clear-all sequence that resets the bank one bit per cycle, and it can optionally read back each flip-flop's Q output. It sits between the requesting logic and the SRFF bank.

## Interface
- NREQ, 4, number of requesters (2..8)
- NBITS, 8, number of SR flip-flops in the bank
- IDXW, 3, width of a bit index; 2**IDXW >= NBITS
- clk  in  1  rising-edge clock shared with the SRFF bank
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  request per requester; held high until its gnt pulse
- op  in  NREQ  per-requester operation: 1 = set, 0 = reset
- idx  in  NREQ*IDXW  per-requester target bit; requester k uses idx[k*IDXW +: IDXW]
- clr_all  in  1  single-cycle pulse that starts the clear-all sequence
- q_in  in  NBITS  q outputs of the SRFF bank
- s_out  out  NBITS  S inputs of the bank
- r_out  out  NBITS  R inputs of the bank
- gnt  out  NREQ  one-hot, one-cycle grant
- busy  out  1  high whenever the state is not IDLE
- err  out  1  sticky readback-mismatch flag

## Operation
- FSM states: IDLE, APPLY, CHECK, CLEAR.
- Reset values:
  - state = IDLE, rr pointer = 0
  - s_out = r_out = 0, gnt = 0, busy = 0, err = 0
  - clr_pend = 0
- IDLE:
  - If clr_all or clr_pend is set: clear clr_pend, load cnt = 0, go to CLEAR. Clear-all has priority over requests.
  - Else if any req is high: pick the first requester at or after the rr pointer (modulo NREQ). Latch its number w, op and idx, then go to APPLY.
- APPLY (one cycle):
  - gnt[w] = 1.
  - If op = 1, drive s_out[idx] = 1; if op = 0, drive r_out[idx] = 1.
  - If idx >= NBITS: drive no pulse, still issue gnt.
  - rr pointer becomes (w+1) mod NREQ.
  - Next state is CHECK.
- CHECK (one cycle):
  - Compare q_in[idx] with op; a mismatch sets err.
  - idx >= NBITS skips the compare.
  - Next state is IDLE.
- CLEAR:
  - Drive r_out[cnt] = 1 for one cycle, then cnt = cnt+1.
  - After the cycle with cnt = NBITS-1, go to IDLE.
  - req is ignored while in CLEAR (no gnt is issued).
  - A clr_all pulse seen in any non-IDLE state sets clr_pend; it is never dropped.
- Invariants, checked every cycle:
  - s_out & r_out == 0
  - popcount(s_out | r_out) <= 1
  - popcount(gnt) <= 1
- err is cleared only by rst.

## Timing
- s_out, r_out, gnt and busy are registered outputs.
- Request to pulse:
  - req seen in IDLE at edge n → APPLY (gnt and S/R pulse) during cycle n+1.
  - The SRFF updates at edge n+2; CHECK samples q_in during cycle n+2.
  - The block is back in IDLE at cycle n+3.
- One operation takes 3 cycles (2 without VERIFY). Maximum rate: one grant per 3 cycles.
- The granted requester drops req in the cycle after its gnt. If req is still high, it is treated as a new request.
- Clear-all: NBITS pulse cycles plus 1 IDLE entry cycle.
- rst in any state: the next cycle is in IDLE with all outputs 0. A partly finished operation or clear-all is abandoned and no gnt is issued.

## Configuration
- SRCTRL_VERIFY_EN defined:
  - The CHECK state and err logic are present.
  - APPLY → CHECK → IDLE.
- SRCTRL_VERIFY_EN undefined:
  - No CHECK state; APPLY → IDLE, so an operation takes 2 cycles.
  - err is tied to 0 and q_in is unused.

## Test plan
- Reset, then a single set: req=0001, op[0]=1, idx0=5 → gnt=0001 and s_out=8'h20 for one cycle, r_out=0. q_in[5]=1 in CHECK, err stays 0.
- Fairness: req=1111 held high, each requester dropping req after its grant → grants in order 0001, 0010, 0100, 1000, 3 cycles apart.
- Clear-all with a pending request: clr_all pulse together with req=0010 → r_out walks 01, 02, 04 … 80 over 8 cycles. Then gnt=0010 arrives in the APPLY cycle after the return to IDLE.
- Readback fault (VERIFY on): reset idx=2 with q_in[2] forced to 1 → err=1 and stays 1 through later operations until rst.
- Invariant sweep: random req/op/idx/clr_all for 10k cycles → s_out & r_out == 0 and popcount(gnt) <= 1 in every cycle.
- Reset mid-APPLY: assert rst in the APPLY cycle → next cycle all outputs 0, rr pointer 0, state IDLE, no extra gnt.

Source files
------------

// File: rtl/srff_bank_ctrl_if.sv
// srff_bank_ctrl_if: requester and SRFF-bank signals of the bank controller
interface srff_bank_ctrl_if #(
  parameter int NREQ = 4,
  parameter int NBITS = 8,
  parameter int IDXW = 3
);
  logic [NREQ-1:0] req, op, gnt;
  logic [NREQ*IDXW-1:0] idx;
  logic clr_all, busy, err;
  logic [NBITS-1:0] q_in, s_out, r_out;
  modport master(output req, op, idx, clr_all, q_in, input s_out, r_out, gnt, busy, err);
  modport slave(input req, op, idx, clr_all, q_in, output s_out, r_out, gnt, busy, err);
endinterface

// File: rtl/srff_bank_ctrl.sv
// srff_bank_ctrl: round-robin set/reset pulse controller for an SRFF bank
// SRCTRL_VERIFY_EN adds the CHECK state and sticky Q-readback error flag
module srff_bank_ctrl #(
  parameter int NREQ = 4,
  parameter int NBITS = 8,
  parameter int IDXW = 3
) (
  input logic clk,
  input logic rst,
  srff_bank_ctrl_if.slave bus
);
  localparam int WW = $clog2(NREQ);
  localparam int CW = $clog2(NBITS + 1);
  typedef enum logic [1:0] {IDLE, APPLY, CHECK, CLEAR} state_t;
  state_t state, state_n;
  logic [WW-1:0] rr, rr_n, w, p;
  logic [CW-1:0] cnt, cnt_n;
  logic clr_pend, clr_pend_n, found, sel_op;
  logic [IDXW-1:0] sel_idx;
  logic [NBITS-1:0] s_n, r_n;
  logic [NREQ-1:0] gnt_n;
  function automatic logic [NBITS-1:0] bit_of(input logic [IDXW-1:0] i);
    return (int'(i) < NBITS) ? NBITS'(1) << i : '0;
  endfunction
  // descending scan so the nearest requester at or after rr wins
  always_comb begin
    found = 1'b0;
    w = '0;
    p = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = WW'((int'(rr) + k) % NREQ);
      if (bus.req[p]) begin
        found = 1'b1;
        w = p;
      end
    end
    sel_op = bus.op[w];
    sel_idx = bus.idx[w*IDXW +: IDXW];
  end
  always_comb begin
    state_n = state;
    rr_n = rr;
    cnt_n = cnt;
    clr_pend_n = clr_pend | bus.clr_all;
    s_n = '0;
    r_n = '0;
    gnt_n = '0;
    case (state)
      IDLE:
        if (bus.clr_all || clr_pend) begin
          clr_pend_n = 1'b0;
          cnt_n = '0;
          r_n = NBITS'(1);
          state_n = CLEAR;
        end else if (found) begin
          gnt_n = NREQ'(1) << w;
          s_n = sel_op ? bit_of(sel_idx) : '0;
          r_n = sel_op ? '0 : bit_of(sel_idx);
          rr_n = (int'(w) == NREQ - 1) ? '0 : w + 1'b1;
          state_n = APPLY;
        end
`ifdef SRCTRL_VERIFY_EN
      APPLY: state_n = CHECK;
`else
      APPLY: state_n = IDLE;
`endif
      CLEAR:
        if (cnt == CW'(NBITS - 1)) state_n = IDLE;
        else begin
          cnt_n = cnt + 1'b1;
          r_n = NBITS'(1) << cnt_n;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rr <= '0;
      cnt <= '0;
      clr_pend <= 1'b0;
      bus.s_out <= '0;
      bus.r_out <= '0;
      bus.gnt <= '0;
      bus.busy <= 1'b0;
    end else begin
      state <= state_n;
      rr <= rr_n;
      cnt <= cnt_n;
      clr_pend <= clr_pend_n;
      bus.s_out <= s_n;
      bus.r_out <= r_n;
      bus.gnt <= gnt_n;
      bus.busy <= state_n != IDLE;
    end
`ifdef SRCTRL_VERIFY_EN
  logic op_q;
  logic [IDXW-1:0] idx_q;
  // op/idx of the granted request stay latched from the last IDLE cycle
  always_ff @(posedge clk)
    if (rst) bus.err <= 1'b0;
    else begin
      if (state == IDLE) begin
        op_q <= sel_op;
        idx_q <= sel_idx;
      end
      if (state == CHECK && int'(idx_q) < NBITS && bus.q_in[idx_q] != op_q) bus.err <= 1'b1;
    end
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_srff_bank_ctrl.sv
// tb_srff_bank_ctrl: directed tests of srff_bank_ctrl against an SRFF bank model
module tb_srff_bank_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [7:0] bank = '0;
  logic [7:0] fmask = '0;
`ifdef SRCTRL_VERIFY_EN
  localparam int OPC = 3;
  localparam logic VER = 1'b1;
`else
  localparam int OPC = 2;
  localparam logic VER = 1'b0;
`endif
  srff_bank_ctrl_if #(.NREQ(4), .NBITS(8), .IDXW(3)) b();
  srff_bank_ctrl_if #(.NREQ(4), .NBITS(6), .IDXW(3)) b2();
  srff_bank_ctrl #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (.clk(clk), .rst(rst), .bus(b));
  srff_bank_ctrl #(.NREQ(4), .NBITS(6), .IDXW(3)) dut2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  always @(posedge clk)
    for (int i = 0; i < 8; i++)
      if (b.s_out[i]) bank[i] <= 1'b1;
      else if (b.r_out[i]) bank[i] <= 1'b0;
  assign b.q_in = bank | fmask;
  assign b2.q_in = '0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    b.req = '0; b.op = '0; b.idx = '0; b.clr_all = 1'b0;
    b2.req = '0; b2.op = '0; b2.idx = '0; b2.clr_all = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (b.s_out !== 8'h00) begin errors++; $display("FAIL reset_s_out: got %h want 00", b.s_out); end
    checks++; if (b.r_out !== 8'h00) begin errors++; $display("FAIL reset_r_out: got %h want 00", b.r_out); end
    checks++; if (b.gnt !== 4'h0) begin errors++; $display("FAIL reset_gnt: got %b want 0000", b.gnt); end
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", b.busy); end
    checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", b.err); end
    rst = 1'b0;
  endtask

  task automatic test_single_set;
    do_reset();
    b.req = 4'b0001; b.op = 4'b0001; b.idx = 12'd5;
    tick();
    checks++; if (b.gnt !== 4'b0001) begin errors++; $display("FAIL set_gnt: got %b want 0001", b.gnt); end
    checks++; if (b.s_out !== 8'h20) begin errors++; $display("FAIL set_s_out: got %h want 20", b.s_out); end
    checks++; if (b.r_out !== 8'h00) begin errors++; $display("FAIL set_r_out: got %h want 00", b.r_out); end
    checks++; if (b.busy !== 1'b1) begin errors++; $display("FAIL set_busy: got %b want 1", b.busy); end
    b.req = '0;
    repeat (OPC - 1) begin
      tick();
      checks++; if (b.gnt !== 4'h0 || b.s_out !== 8'h00) begin errors++; $display("FAIL set_after: gnt %b s_out %h want 0000 00", b.gnt, b.s_out); end
    end
    checks++; if (bank[5] !== 1'b1) begin errors++; $display("FAIL set_bank: got %b want 1", bank[5]); end
    checks++; if (b.busy !== 1'b0) begin errors++; $display("FAIL set_idle: busy %b want 0", b.busy); end
    checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL set_err: got %b want 0", b.err); end
  endtask

  task automatic test_fairness;
    do_reset();
    b.op = 4'hF; b.idx = {3'd3, 3'd2, 3'd1, 3'd0}; b.req = 4'hF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (b.gnt !== 4'(1 << i)) begin errors++; $display("FAIL fair_gnt%0d: got %b want %b", i, b.gnt, 4'(1 << i)); end
      checks++; if (b.s_out !== 8'(1 << i)) begin errors++; $display("FAIL fair_s%0d: got %h want %h", i, b.s_out, 8'(1 << i)); end
      b.req = b.req & ~4'(1 << i);
      repeat (OPC - 1) begin
        tick();
        checks++; if (b.gnt !== 4'h0) begin errors++; $display("FAIL fair_gap%0d: got %b want 0000", i, b.gnt); end
      end
    end
    checks++; if (bank[3:0] !== 4'hF) begin errors++; $display("FAIL fair_bank: got %h want f", bank[3:0]); end
  endtask

  task automatic test_clear_pending_req;
    do_reset();
    b.req = 4'b0010; b.op = 4'b0000; b.idx = 12'(7 << 3); b.clr_all = 1'b1;
    tick();
    b.clr_all = 1'b0;
    for (int c = 0; c < 8; c++) begin
      checks++; if (b.r_out !== 8'(1 << c) || b.gnt !== 4'h0) begin errors++; $display("FAIL clr_walk%0d: r_out %h gnt %b want %h 0000", c, b.r_out, b.gnt, 8'(1 << c)); end
      tick();
    end
    checks++; if (b.r_out !== 8'h00 || b.gnt !== 4'h0 || b.busy !== 1'b0) begin errors++; $display("FAIL clr_idle: r_out %h gnt %b busy %b want 00 0000 0", b.r_out, b.gnt, b.busy); end
    checks++; if (bank !== 8'h00) begin errors++; $display("FAIL clr_bank: got %h want 00", bank); end
    tick();
    checks++; if (b.gnt !== 4'b0010 || b.r_out !== 8'h80) begin errors++; $display("FAIL clr_then_gnt: gnt %b r_out %h want 0010 80", b.gnt, b.r_out); end
    b.req = '0;
    repeat (OPC - 1) tick();
  endtask

  task automatic test_clear_during_op;
    do_reset();
    b.req = 4'b0001; b.op = 4'b0001; b.idx = 12'd4;
    tick();
    b.req = '0; b.clr_all = 1'b1;
    tick();
    b.clr_all = 1'b0;
    repeat (OPC - 2) tick();
    tick();
    checks++; if (b.r_out !== 8'h01 || b.busy !== 1'b1) begin errors++; $display("FAIL pend_clear_start: r_out %h busy %b want 01 1", b.r_out, b.busy); end
    repeat (8) tick();
    checks++; if (b.busy !== 1'b0 || bank !== 8'h00) begin errors++; $display("FAIL pend_clear_end: busy %b bank %h want 0 00", b.busy, bank); end
  endtask

  task automatic test_readback_fault;
    do_reset();
    fmask = 8'h04;
    b.req = 4'b0001; b.op = 4'b0000; b.idx = 12'd2;
    tick();
    checks++; if (b.r_out !== 8'h04) begin errors++; $display("FAIL fault_r_out: got %h want 04", b.r_out); end
    b.req = '0;
    repeat (OPC - 1) tick();
    checks++; if (b.err !== VER) begin errors++; $display("FAIL fault_err: got %b want %b", b.err, VER); end
    fmask = 8'h00;
    b.req = 4'b0010; b.op = 4'b0010; b.idx = 12'(3 << 3);
    tick();
    b.req = '0;
    repeat (OPC - 1) tick();
    checks++; if (b.err !== VER) begin errors++; $display("FAIL fault_sticky: got %b want %b", b.err, VER); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b.err !== 1'b0) begin errors++; $display("FAIL fault_rst: got %b want 0", b.err); end
  endtask

  task automatic test_out_of_range;
    do_reset();
    b2.req = 4'b0001; b2.op = 4'b0001; b2.idx = 12'd6;
    tick();
    checks++; if (b2.gnt !== 4'b0001) begin errors++; $display("FAIL oor_gnt: got %b want 0001", b2.gnt); end
    checks++; if (b2.s_out !== 6'h00 || b2.r_out !== 6'h00) begin errors++; $display("FAIL oor_pulse: s %h r %h want 00 00", b2.s_out, b2.r_out); end
    b2.req = '0;
    repeat (OPC - 1) tick();
    checks++; if (b2.err !== 1'b0 || b2.busy !== 1'b0) begin errors++; $display("FAIL oor_done: err %b busy %b want 0 0", b2.err, b2.busy); end
  endtask

  task automatic test_reset_mid_apply;
    do_reset();
    b.req = 4'b0100; b.op = 4'b0100; b.idx = 12'(1 << 6);
    tick();
    checks++; if (b.gnt !== 4'b0100) begin errors++; $display("FAIL mid_gnt: got %b want 0100", b.gnt); end
    rst = 1'b1; b.req = '0;
    tick();
    checks++; if (b.gnt !== 4'h0 || b.s_out !== 8'h00 || b.r_out !== 8'h00 || b.busy !== 1'b0) begin errors++; $display("FAIL mid_outs: gnt %b s %h r %h busy %b want all 0", b.gnt, b.s_out, b.r_out, b.busy); end
    rst = 1'b0;
    tick();
    checks++; if (b.gnt !== 4'h0 || b.busy !== 1'b0) begin errors++; $display("FAIL mid_extra: gnt %b busy %b want 0000 0", b.gnt, b.busy); end
    b.req = 4'b1010; b.op = 4'b0000; b.idx = '0;
    tick();
    checks++; if (b.gnt !== 4'b0010) begin errors++; $display("FAIL mid_rr: got %b want 0010", b.gnt); end
    b.req = '0;
    repeat (OPC - 1) tick();
  endtask

  task automatic test_invariants;
    do_reset();
    for (int n = 0; n < 10000; n++) begin
      b.req = 4'($urandom); b.op = 4'($urandom); b.idx = 12'($urandom);
      b.clr_all = ($urandom_range(0, 63) == 0);
      tick();
      checks++; if ((b.s_out & b.r_out) !== 8'h00) begin errors++; $display("FAIL inv_sr%0d: got %h want 00", n, b.s_out & b.r_out); end
      checks++; if ($countones(b.s_out | b.r_out) > 1) begin errors++; $display("FAIL inv_pulse%0d: got %h want <=1 bit", n, b.s_out | b.r_out); end
      checks++; if ($countones(b.gnt) > 1) begin errors++; $display("FAIL inv_gnt%0d: got %b want <=1 bit", n, b.gnt); end
    end
    idle_inputs();
    repeat (20) tick();
    checks++; if (b.busy !== 1'b0 || b.err !== 1'b0) begin errors++; $display("FAIL inv_end: busy %b err %b want 0 0", b.busy, b.err); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_set();
    test_fairness();
    test_clear_pending_req();
    test_clear_during_op();
    test_readback_fault();
    test_out_of_range();
    test_reset_mid_apply();
    test_invariants();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
